// File: rtl/matmul_cfg_if.sv
// matmul_cfg_if: write/commit/readback bus between a config master and the loader.
interface matmul_cfg_if #(
  parameter int AW    = 2,
  parameter int CFG_W = 32,
  parameter int IMG_W = 115
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [AW-1:0]    cfg_addr;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_commit;
  logic             eng_busy;
  logic [IMG_W-1:0] act_img;
  logic             act_valid;
  logic             cfg_done;
  logic             cfg_err;
  logic [AW-1:0]    cfg_rd_addr;
  logic [CFG_W-1:0] cfg_rd_data;
  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_commit, eng_busy, cfg_rd_addr,
    input  cfg_ready, act_img, act_valid, cfg_done, cfg_err, cfg_rd_data
  );
  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_commit, eng_busy, cfg_rd_addr,
    output cfg_ready, act_img, act_valid, cfg_done, cfg_err, cfg_rd_data
  );
endinterface

// File: rtl/matmul_cfg_loader.sv
// matmul_cfg_loader: shadow config image, range-checked busy-interlocked commit into the active image.
// Readback of shadow words is built only when MATMUL_CFG_READBACK_EN is defined.
module matmul_cfg_loader #(
  parameter int WIDTH  = 8,
  parameter int ROW    = 4,
  parameter int COL    = 4,
  parameter int W_SIZE = 256,
  parameter int I_SIZE = 256,
  parameter int O_SIZE = 256,
  parameter int CFG_W  = 32
) (
  input logic          clk,
  input logic          reset,
  matmul_cfg_if.slave  bus
);
  localparam int DRIVER_WIDTH = WIDTH * (ROW + COL);
  localparam int RW = $clog2(ROW);
  localparam int CW = $clog2(COL);
  localparam int IW = $clog2(I_SIZE);
  localparam int WW = $clog2(W_SIZE);
  localparam int OW = $clog2(O_SIZE);
  localparam int DC_W = RW + CW + IW + WW + IW + 2 * OW + 1;
  localparam int TC_W = 6 + DRIVER_WIDTH;
  localparam int IMG_W = DC_W + TC_W;
  localparam int NWORDS = (IMG_W + CFG_W - 1) / CFG_W;
  localparam int AW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  localparam int P_O  = 1;
  localparam int P_P  = P_O + OW;
  localparam int P_IO = P_P + OW;
  localparam int P_WO = P_IO + IW;
  localparam int P_IR = P_WO + WW;
  localparam int P_WR = P_IR + IW + CW;
  typedef enum logic [1:0] {IDLE, PEND, CHECK, APPLY} state_t;
  state_t           state_q, state_d;
  logic [IMG_W-1:0] shadow_q, shadow_d, act_img_q, act_img_d;
  logic             act_valid_q, act_valid_d, done_q, done_d, err_q, err_d, chk_q, chk_d;
  logic [AW-1:0]    addr;
  logic             wr, ok;
  logic [IW-1:0]    i_rows;
  logic [IW:0]      i_sum;
  logic [OW:0]      o_sum, p_sum;
  logic [WW:0]      w_sum;
  assign addr   = bus.cfg_addr;
  assign wr     = bus.cfg_valid && state_q == IDLE;
  assign i_rows = shadow_q[P_IR +: IW];
  assign i_sum  = (IW+1)'(shadow_q[P_IO +: IW]) + (IW+1)'(i_rows);
  assign o_sum  = (OW+1)'(shadow_q[P_O +: OW]) + (OW+1)'(i_rows);
  assign p_sum  = (OW+1)'(shadow_q[P_P +: OW]) + (OW+1)'(i_rows);
  assign w_sum  = (WW+1)'(shadow_q[P_WO +: WW]) + (WW+1)'(shadow_q[P_WR +: RW]);
  assign ok = i_sum <= (IW+1)'(I_SIZE - 1) && o_sum <= (OW+1)'(O_SIZE - 1) &&
              (!shadow_q[0] || p_sum <= (OW+1)'(O_SIZE - 1)) && w_sum <= (WW+1)'(W_SIZE - 1);
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    act_img_d   = act_img_q;
    act_valid_d = act_valid_q;
    done_d      = 1'b0;
    err_d       = err_q;
    chk_d       = chk_q;
    // Bits past IMG_W and words past NWORDS simply have no shadow bit to land in.
    for (int i = 0; i < IMG_W; i++)
      if (wr && i / CFG_W == int'(addr)) shadow_d[i] = bus.cfg_data[i % CFG_W];
    unique case (state_q)
      IDLE:  if (bus.cfg_commit) state_d = bus.eng_busy ? PEND : CHECK;
      PEND:  if (!bus.eng_busy) state_d = CHECK;
      CHECK: begin
        chk_d   = ok;
        state_d = APPLY;
      end
      APPLY: begin
        state_d     = IDLE;
        act_img_d   = chk_q ? shadow_q : act_img_q;
        act_valid_d = act_valid_q | chk_q;
        done_d      = chk_q;
        err_d       = !chk_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      act_img_q   <= '0;
      act_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      chk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      act_img_q   <= act_img_d;
      act_valid_q <= act_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      chk_q       <= chk_d;
    end
  end
  assign bus.cfg_ready = state_q == IDLE;
  assign bus.act_img   = act_img_q;
  assign bus.act_valid = act_valid_q;
  assign bus.cfg_done  = done_q;
  assign bus.cfg_err   = err_q;
`ifdef MATMUL_CFG_READBACK_EN
  logic [CFG_W-1:0] rd_q, rd_d;
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < IMG_W; i++)
      if (i / CFG_W == int'(bus.cfg_rd_addr)) rd_d[i % CFG_W] = shadow_q[i];
  end
  always_ff @(posedge clk) rd_q <= reset ? '0 : rd_d;
  assign bus.cfg_rd_data = rd_q;
`else
  assign bus.cfg_rd_data = '0;
`endif
endmodule

// File: tb/tb_matmul_cfg_loader.sv
// tb_matmul_cfg_loader: directed checks of write, commit timing, range errors, busy interlock and readback.
module tb_matmul_cfg_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_asrt = 0;
  int   n_fail = 0;
  int   n_done;
  logic [114:0] img_a, img_b, img_c, img_c3;
  logic [31:0]  exp_rd3, exp_rd0;
  matmul_cfg_if #(.AW(2), .CFG_W(32), .IMG_W(115)) bus ();
  matmul_cfg_loader dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [114:0] mk(input logic [7:0] irows, input logic [7:0] ioff, input logic [7:0] ooff);
    return {3'd0, 2'd1, 1'b1, 64'hDEAD_BEEF_0123_4567, 2'd3, 2'd3, irows, 8'd0, ioff, 8'd0, ooff, 1'b0};
  endfunction
  task automatic wr_word(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_data  = d;
    tick();
    bus.cfg_valid = 1'b0;
  endtask
  task automatic wr_img(input logic [114:0] img);
    logic [127:0] pad;
    pad = {13'd0, img};
    for (int k = 0; k < 4; k++) wr_word(2'(k), pad[k*32 +: 32]);
  endtask
  task automatic commit();
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
  endtask
  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_commit = 1'b0;
    bus.eng_busy = 1'b0; bus.cfg_rd_addr = '0;
    img_a  = mk(8'd55, 8'd200, 8'd0);
    img_b  = mk(8'd56, 8'd200, 8'd0);
    img_c  = mk(8'd20, 8'd10, 8'd30);
    img_c3 = {19'h7FFFF, img_c[95:0]};
`ifdef MATMUL_CFG_READBACK_EN
    exp_rd3 = 32'h0007_FFFF;
    exp_rd0 = img_c[31:0];
`else
    exp_rd3 = 32'h0;
    exp_rd0 = 32'h0;
`endif
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_act_img", 128'(bus.act_img), 128'd0);
    chk("rst_act_valid", 128'(bus.act_valid), 128'd0);
    chk("rst_ready", 128'(bus.cfg_ready), 128'd1);
    chk("rst_err", 128'(bus.cfg_err), 128'd0);
    chk("rst_done", 128'(bus.cfg_done), 128'd0);
    chk("rst_rd", 128'(bus.cfg_rd_data), 128'd0);
    wr_img(img_a);
    commit();
    chk("ok_t1_ready", 128'(bus.cfg_ready), 128'd0);
    chk("ok_t1_done", 128'(bus.cfg_done), 128'd0);
    tick();
    chk("ok_t2_ready", 128'(bus.cfg_ready), 128'd0);
    chk("ok_t2_img", 128'(bus.act_img), 128'd0);
    tick();
    chk("ok_t3_done", 128'(bus.cfg_done), 128'd1);
    chk("ok_t3_img", 128'(bus.act_img), 128'(img_a));
    chk("ok_t3_valid", 128'(bus.act_valid), 128'd1);
    chk("ok_t3_ready", 128'(bus.cfg_ready), 128'd1);
    chk("ok_t3_err", 128'(bus.cfg_err), 128'd0);
    tick();
    chk("ok_t4_done", 128'(bus.cfg_done), 128'd0);
    wr_img(img_b);
    commit(); tick(); tick();
    chk("bad_err", 128'(bus.cfg_err), 128'd1);
    chk("bad_done", 128'(bus.cfg_done), 128'd0);
    chk("bad_img", 128'(bus.act_img), 128'(img_a));
    tick();
    chk("bad_err_sticky", 128'(bus.cfg_err), 128'd1);
    wr_img(img_a);
    commit(); tick(); tick();
    chk("clr_err", 128'(bus.cfg_err), 128'd0);
    chk("clr_done", 128'(bus.cfg_done), 128'd1);
    wr_img(img_c);
    bus.eng_busy = 1'b1;
    commit();
    chk("pend_ready", 128'(bus.cfg_ready), 128'd0);
    tick();
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    chk("pend_img", 128'(bus.act_img), 128'(img_a));
    tick(); tick();
    chk("pend_done", 128'(bus.cfg_done), 128'd0);
    chk("pend_img2", 128'(bus.act_img), 128'(img_a));
    bus.eng_busy = 1'b0;
    tick();
    chk("busy_chk_ready", 128'(bus.cfg_ready), 128'd0);
    bus.eng_busy = 1'b1;
    tick();
    chk("busy_apply_done", 128'(bus.cfg_done), 128'd0);
    tick();
    chk("busy_t3_done", 128'(bus.cfg_done), 128'd1);
    chk("busy_t3_img", 128'(bus.act_img), 128'(img_c));
    bus.eng_busy = 1'b0;
    n_done = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_done += int'(bus.cfg_done);
    end
    chk("busy_single_done", 128'(n_done), 128'd0);
    wr_word(2'd3, 32'hFFFF_FFFF);
    bus.cfg_rd_addr = 2'd3;
    tick();
    chk("rd_word3", 128'(bus.cfg_rd_data), 128'(exp_rd3));
    bus.cfg_rd_addr = 2'd0;
    tick();
    chk("rd_word0", 128'(bus.cfg_rd_data), 128'(exp_rd0));
    commit(); tick(); tick();
    chk("trunc_done", 128'(bus.cfg_done), 128'd1);
    chk("trunc_img", 128'(bus.act_img), 128'(img_c3));
    tick();
    commit();
    chk("rstchk_ready", 128'(bus.cfg_ready), 128'd0);
    reset = 1'b1;
    tick();
    chk("rstchk_img", 128'(bus.act_img), 128'd0);
    chk("rstchk_valid", 128'(bus.act_valid), 128'd0);
    chk("rstchk_ready", 128'(bus.cfg_ready), 128'd1);
    reset = 1'b0;
    tick(); tick();
    chk("rstchk_done", 128'(bus.cfg_done), 128'd0);
    chk("rstchk_rd", 128'(bus.cfg_rd_data), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
